// File: rtl/gcd_req_arbiter.sv
// Round-robin front end that shares one GCD unit among NREQ val/rdy requesters.
// Optional zero-operand bypass: define GCD_ARB_ZERO_BYPASS_EN.
module gcd_req_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_val,
  output logic [NREQ-1:0]         req_rdy,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic [NREQ-1:0]         resp_val,
  input  logic [NREQ-1:0]         resp_rdy,
  output logic [W-1:0]            resp_result,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic                    gcd_in_val,
  output logic [W-1:0]            gcd_a,
  output logic [W-1:0]            gcd_b,
  input  logic                    gcd_result_rdy,
  input  logic [W-1:0]            gcd_result,
  output logic                    gcd_result_taken
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;

  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   scan;
  logic [W-1:0]  sel_a, sel_b;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin : rr_pick
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (req_val[scan[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IW-1:0];
      end
    end
  end

  assign sel_a = req_a[gnt_idx*W +: W];
  assign sel_b = req_b[gnt_idx*W +: W];

  always_comb begin : fsm
    state_d          = state_q;
    ptr_d            = ptr_q;
    id_d             = id_q;
    a_d              = a_q;
    b_d              = b_q;
    res_d            = res_q;
    req_rdy          = '0;
    resp_val         = '0;
    gcd_in_val       = 1'b0;
    gcd_result_taken = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_rdy = NREQ'(1) << gnt_idx;
          id_d    = gnt_idx;
          a_d     = sel_a;
          b_d     = sel_b;
`ifdef GCD_ARB_ZERO_BYPASS_EN
          if (sel_a == '0 || sel_b == '0) begin
            res_d   = sel_a | sel_b;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        gcd_in_val = 1'b1;
        state_d    = BUSY;
      end
      BUSY: begin
        if (gcd_result_rdy) begin
          gcd_result_taken = 1'b1;
          res_d            = gcd_result;
          state_d          = RESP;
        end
      end
      RESP: begin
        resp_val = NREQ'(1) << id_q;
        if (resp_rdy[id_q]) begin
          state_d = IDLE;
          ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Synchronous reset still lets the old state show for one cycle; keep handshakes quiet.
    if (!reset) begin
      req_rdy          = '0;
      resp_val         = '0;
      gcd_in_val       = 1'b0;
      gcd_result_taken = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign gcd_a       = a_q;
  assign gcd_b       = b_q;
  assign resp_result = res_q;
  assign resp_id     = id_q;

endmodule
